reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-read-port, single-write-port integer register file for the RISC-V core.
- Replaces the op-triggered, unclocked register file; fully synchronous, with registered reads.
- Adds a per-register busy scoreboard so decode can stall on pending writebacks.
- Sits between decode (read / reserve) and writeback (write / release).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, 5, address width; must equal log2(NREGS).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  NRD  per-port read strobe.
- rd_addr  in  NRD*AW  read addresses; port p uses bits [p*AW +: AW].
- rd_data  out  NRD*XLEN  registered read data, one field per port.
- rd_busy  out  NRD  registered busy flag of the addressed register.
- rd_valid  out  NRD  high one cycle after the matching rd_en.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- rsv_en  in  1  mark register rsv_addr busy (instruction issued).
- rsv_addr  in  AW  register to reserve.
- busy_vec  out  NREGS  live scoreboard, one bit per register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers 0; busy_vec 0; rd_data 0; rd_busy 0; rd_valid 0.
  - An operation in flight is discarded; the first valid read after release returns 0.
- Write: on a clk edge with wr_en, registers[wr_addr] <= wr_data.
  - When ZERO_REG=1 and wr_addr==0, the write is dropped.
- Read, latency 1 cycle:
  - on a clk edge with rd_en[p], capture the data and busy bit of rd_addr[p] into the port p outputs; rd_valid[p] <= 1.
  - without rd_en[p], rd_data[p] and rd_busy[p] hold their values; rd_valid[p] <= 0.
- Read of address 0 with ZERO_REG=1 always returns data 0 and busy 0.
- Same-cycle write and read of the same address: see Optional Feature.
- Any number of ports may read the same address in the same cycle; all get identical results.
- Scoreboard:
  - rsv_en sets busy[rsv_addr]; wr_en clears busy[wr_addr].
  - Same address, both in one cycle: reserve wins, busy stays 1 (a new producer issued).
  - Different addresses: both take effect.
  - rsv_en on an already-busy register: stays busy (no counting; WAW is decode's concern).
  - wr_en on a non-busy register: the write occurs and busy stays 0.
  - ZERO_REG=1: reserve or release of register 0 is ignored.
- rd_busy[p] reflects the scoreboard before that edge's reserve/release updates, unless the Optional Feature is compiled in.
- busy_vec is driven directly from the scoreboard flops.
- Address width is exact: no out-of-range addresses exist.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined (write-first):
  - rd_en[p] and wr_en in the same cycle with rd_addr[p]==wr_addr (and not zero-reg) gives rd_data[p] = wr_data.
  - rd_busy[p] reflects the post-update scoreboard state for that address.
- Undefined (read-first):
  - rd_data[p] returns the pre-write value.
  - rd_busy[p] returns the pre-update busy bit.

Decomposition:
- Package regfile_pkg: XLEN and NREGS defaults, AW derivation, a reg-index typedef, constant ZERO_IDX.
- Sub-module reg_scoreboard holds the NREGS busy flops, reserve/release priority and zero-reg masking.
- The top level holds the storage array, the read port generate loop and bypass muxing.

Test Plan:
- Reset: pulse rst_n low mid-cycle after writing reg 5 = 0xDEADBEEF -> the next cycle's read of reg 5 gives 0, busy_vec 0, rd_valid 0 during reset.
- Write then read: write reg 7 = 0x12345678; next cycle rd_en[0] on 7 and rd_en[1] on 7 -> both ports show 0x12345678 one cycle later with rd_valid=2'b11.
- Zero register: write reg 0 = 0xFFFFFFFF and reserve reg 0 -> read returns 0, busy_vec[0]=0.
- Collision: reg 3 holds 0x1, same cycle write reg 3 = 0x2 and read reg 3 -> 0x2 with REGFILE_BYPASS_EN defined, 0x1 without; the following read returns 0x2 in both builds.
- Scoreboard: reserve reg 9 -> busy_vec[9]=1; later, reserve 9 and write 9 in the same cycle -> stays 1; a lone write to 9 -> 0.
- Hold: rd_en low for 3 cycles after a read of 0xA5A5A5A5 -> rd_data holds 0xA5A5A5A5, rd_valid 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// +------------------------------------------------------------------+
// | regfile_pkg : shared defaults and index types for reg_file_mp    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int c_XLEN  = 32;
  localparam int c_NREGS = 32;
  localparam int c_AW    = $clog2(c_NREGS);

  typedef logic [c_AW-1:0] reg_idx_t;

  localparam reg_idx_t c_ZERO_IDX = '0;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// +------------------------------------------------------------------+
// | reg_scoreboard : per-register busy flags (reserve / release)     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = c_NREGS,
  parameter int AW       = c_AW,
  parameter int ZERO_REG = 1,
  parameter int RD_POST  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             rel_en,
  input  logic [AW-1:0]    rel_addr,
  output logic [NREGS-1:0] busy_vec,
  output logic [NREGS-1:0] busy_view
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_bit
      if (ZERO_REG != 0 && i == 0) begin : g_zero
        assign w_busy_nxt[i] = 1'b0;
      end else begin : g_live
        logic w_set;
        logic w_clr;
        assign w_set = rsv_en && (rsv_addr == AW'(i));
        assign w_clr = rel_en && (rel_addr == AW'(i));
        // A fresh reservation outranks the release of the previous producer.
        assign w_busy_nxt[i] = w_set ? 1'b1 : (w_clr ? 1'b0 : r_busy[i]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec  = r_busy;
  assign busy_view = (RD_POST != 0) ? w_busy_nxt : r_busy;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// +------------------------------------------------------------------+
// | reg_file_mp : NRD-read / 1-write register file with scoreboard   |
// | Define REGFILE_BYPASS_EN for write-first same-cycle reads.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = c_XLEN,
  parameter int NREGS    = c_NREGS,
  parameter int AW       = c_AW,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  output logic [NRD-1:0]      rd_valid,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREGS-1:0]    busy_vec
);

`ifdef REGFILE_BYPASS_EN
  localparam bit c_BYPASS = 1'b1;
`else
  localparam bit c_BYPASS = 1'b0;
`endif

  localparam logic [AW-1:0] c_ZADDR = AW'(c_ZERO_IDX);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy_view;
  logic             w_wr_ok;

  assign w_wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == c_ZADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .RD_POST  (c_BYPASS ? 1 : 0)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rel_en    (wr_en),
    .rel_addr  (wr_addr),
    .busy_vec  (busy_vec),
    .busy_view (w_busy_view)
  );

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic            w_zero;
      logic            w_hit;
      logic [XLEN-1:0] w_data;
      logic            w_busy;
      logic [XLEN-1:0] r_data;
      logic            r_busy;
      logic            r_valid;

      assign w_addr = rd_addr[p*AW +: AW];
      assign w_zero = (ZERO_REG != 0) && (w_addr == c_ZADDR);
      assign w_hit  = c_BYPASS && w_wr_ok && (wr_addr == w_addr);

      always_comb begin
        w_data = r_regs[w_addr];
        w_busy = w_busy_view[w_addr];
        if (w_zero) begin
          w_data = '0;
          w_busy = 1'b0;
        end else if (w_hit) begin
          w_data = wr_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data  <= '0;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= rd_en[p];
          if (rd_en[p]) begin
            r_data <= w_data;
            r_busy <= w_busy;
          end
        end
      end

      assign rd_data[p*XLEN +: XLEN] = r_data;
      assign rd_busy[p]              = r_busy;
      assign rd_valid[p]             = r_valid;
    end
  endgenerate

endmodule

`default_nettype wire
